// File: rtl/mprj_io_mux_pkg.sv
// mprj_io_mux_pkg
// Shared definitions for the pad arbiter: register offsets within the
// Wishbone window, the hand-over state encoding and STATUS field positions.
package mprj_io_mux_pkg;

   localparam logic [7:0] REG_SEL    = 8'h00;
   localparam logic [7:0] REG_CTRL   = 8'h04;
   localparam logic [7:0] REG_STATUS = 8'h08;

   typedef enum logic [1:0] {
      ST_OFF    = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2
   } state_t;

   localparam int CTRL_EN_BIT      = 0;
   localparam int STATUS_STATE_LSB = 0;
   localparam int STATUS_OWNER_LSB = 8;
   localparam int STATUS_ERR_BIT   = 16;

endpackage

// File: rtl/mprj_io_mux_if.sv
// mprj_io_mux_if
// Wishbone classic slave bundle between the management SoC and the pad
// arbiter.
//   cyc, stb, we  : bus strobes (master -> slave)
//   sel           : byte enables, only bit 0 is honoured by the arbiter
//   adr, dat_w    : address and write data
//   ack, dat_r    : acknowledge and read data (slave -> master)
interface mprj_io_mux_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] adr;
   logic [31:0] dat_w;
   logic        ack;
   logic [31:0] dat_r;

   modport master (output cyc, stb, we, sel, adr, dat_w, input ack, dat_r);
   modport slave  (input cyc, stb, we, sel, adr, dat_w, output ack, dat_r);
endinterface

// File: rtl/mprj_io_mux_wb_regs.sv
// mprj_io_mux_wb_regs
// Wishbone decode, single-cycle ack and the SEL/CTRL/ERR registers.
//   clk, rst     : clock, async active-high reset
//   wb           : Wishbone slave bundle
//   state, owner : live FSM state and owner, reflected in STATUS
//   sel_q, en_q  : target owner and enable registers
//   sel_wr_stb   : one-cycle pulse in the ack cycle of a valid SEL write
module mprj_io_mux_wb_regs
   import mprj_io_mux_pkg::*;
#(
   parameter int          NUM_PROJ = 4,
   parameter logic [31:0] BASE_ADR = 32'h3000_0000,
   parameter int          SEL_W    = 2
) (
   input  logic             clk,
   input  logic             rst,
   mprj_io_mux_if.slave     wb,
   input  state_t           state,
   input  logic [SEL_W-1:0] owner,
   output logic [SEL_W-1:0] sel_q,
   output logic             en_q,
   output logic             sel_wr_stb
);

   logic        in_win;
   logic        req;
   logic        served;
   logic        acc;
   logic        wr;
   logic        sel_valid;
   logic        err_q;
   logic [31:0] status;
   logic [31:0] rd_data;
   logic        unused_sel;

   assign unused_sel = ^wb.sel[3:1];

   assign in_win    = (wb.adr[31:8] == BASE_ADR[31:8]);
   assign req       = wb.cyc & wb.stb & in_win;
   // served holds off a second ack until the strobe drops
   assign acc       = req & ~served;
   assign wr        = acc & wb.we & wb.sel[0];
   assign sel_valid = (wb.dat_w < 32'(NUM_PROJ));

   always_comb begin
      status = '0;
      status[STATUS_STATE_LSB +: 2]     = state;
      status[STATUS_OWNER_LSB +: SEL_W] = owner;
      status[STATUS_ERR_BIT]            = err_q;
      rd_data = '0;
      case (wb.adr[7:0])
         REG_SEL:    rd_data = 32'(sel_q);
         REG_CTRL:   rd_data[CTRL_EN_BIT] = en_q;
         REG_STATUS: rd_data = status;
         default:    rd_data = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb.ack     <= 1'b0;
         wb.dat_r   <= '0;
         served     <= 1'b0;
         sel_q      <= '0;
         en_q       <= 1'b0;
         err_q      <= 1'b0;
         sel_wr_stb <= 1'b0;
      end else begin
         wb.ack     <= acc;
         wb.dat_r   <= (acc & ~wb.we) ? rd_data : '0;
         served     <= req & (served | acc);
         sel_wr_stb <= 1'b0;
         if (wr) begin
            case (wb.adr[7:0])
               REG_SEL: begin
                  if (sel_valid) begin
                     sel_q      <= wb.dat_w[SEL_W-1:0];
                     sel_wr_stb <= 1'b1;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
               REG_CTRL:   en_q  <= wb.dat_w[CTRL_EN_BIT];
               REG_STATUS: err_q <= 1'b0;
               default:    ;
            endcase
         end
      end
   end

endmodule

// File: rtl/mprj_io_mux.sv
// mprj_io_mux
// Wishbone-controlled pad arbiter: one of NUM_PROJ user projects owns the
// whole pad bank; ownership changes pass through a tristated guard window.
//   wb_clk_i, wb_rst_i        : clock, async active-high reset
//   wbs                       : Wishbone slave bundle (SEL/CTRL/STATUS)
//   io_in / io_out / io_oeb   : Caravel pad bank (outputs registered)
//   proj_io_in/out/oeb        : per-project pad slices, PAD_W bits each
//   proj_rst                  : per-project reset, only the owner released
//   user_irq                  : one-cycle pulse when a hand-over completes
//
// state  | meaning
// OFF    | pads tristate, every project held in reset, waiting for EN
// DRAIN  | pads tristate, all projects in reset, guard counter running
// ACTIVE | owner drives pads and sees io_in, owner out of reset
module mprj_io_mux
   import mprj_io_mux_pkg::*;
#(
   parameter int          NUM_PROJ     = 4,
   parameter int          PAD_W        = 38,
   parameter logic [31:0] BASE_ADR     = 32'h3000_0000,
   parameter int          GUARD_CYCLES = 4
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_i,
   mprj_io_mux_if.slave              wbs,
   input  logic [PAD_W-1:0]          io_in,
   output logic [PAD_W-1:0]          io_out,
   output logic [PAD_W-1:0]          io_oeb,
   output logic [NUM_PROJ*PAD_W-1:0] proj_io_in,
   input  logic [NUM_PROJ*PAD_W-1:0] proj_io_out,
   input  logic [NUM_PROJ*PAD_W-1:0] proj_io_oeb,
   output logic [NUM_PROJ-1:0]       proj_rst,
   output logic                      user_irq
);

   localparam int SEL_W = $clog2(NUM_PROJ);
   localparam int CNT_W = $clog2(GUARD_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(GUARD_CYCLES - 1);

   state_t           state;
   logic [SEL_W-1:0] owner;
   logic [SEL_W-1:0] target;
   logic [SEL_W-1:0] sel_q;
   logic [CNT_W-1:0] cnt;
   logic             en_q;
   logic             sel_wr_stb;
   logic [PAD_W-1:0] mux_out;
   logic [PAD_W-1:0] mux_oeb;

   mprj_io_mux_wb_regs #(
      .NUM_PROJ (NUM_PROJ),
      .BASE_ADR (BASE_ADR),
      .SEL_W    (SEL_W)
   ) u_wb_regs (
      .clk        (wb_clk_i),
      .rst        (wb_rst_i),
      .wb         (wbs),
      .state      (state),
      .owner      (owner),
      .sel_q      (sel_q),
      .en_q       (en_q),
      .sel_wr_stb (sel_wr_stb)
   );

   // Guard counter counts down from GUARD_CYCLES-1; terminal count is zero.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state    <= ST_OFF;
         owner    <= '0;
         target   <= '0;
         cnt      <= '0;
         proj_rst <= '1;
         user_irq <= 1'b0;
      end else begin
         user_irq <= 1'b0;
         case (state)
            ST_OFF: begin
               if (en_q) begin
                  state  <= ST_DRAIN;
                  target <= sel_q;
                  cnt    <= CNT_LOAD;
               end
            end
            ST_ACTIVE: begin
               if (!en_q) begin
                  state    <= ST_OFF;
                  proj_rst <= '1;
               end else if (sel_wr_stb && (sel_q != owner)) begin
                  state    <= ST_DRAIN;
                  target   <= sel_q;
                  cnt      <= CNT_LOAD;
                  proj_rst <= '1;
               end
            end
            ST_DRAIN: begin
               if (!en_q) begin
                  state <= ST_OFF;
               end else if (sel_wr_stb) begin
                  target <= sel_q;
                  cnt    <= CNT_LOAD;
               end else if (cnt == '0) begin
                  state    <= ST_ACTIVE;
                  owner    <= target;
                  proj_rst <= ~(NUM_PROJ'(1) << target);
                  user_irq <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state    <= ST_OFF;
               proj_rst <= '1;
            end
         endcase
      end
   end

   always_comb begin
      mux_out    = '0;
      mux_oeb    = '1;
      proj_io_in = '0;
      for (int p = 0; p < NUM_PROJ; p++) begin
         if (owner == SEL_W'(p)) begin
            mux_out = proj_io_out[p*PAD_W +: PAD_W];
            mux_oeb = proj_io_oeb[p*PAD_W +: PAD_W];
            if (state == ST_ACTIVE) begin
               proj_io_in[p*PAD_W +: PAD_W] = io_in;
            end
         end
      end
   end

   // Pads follow the registered state, so a new owner only reaches the
   // pads once it has spent a full cycle out of reset.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         io_out <= '0;
         io_oeb <= '1;
      end else if (state == ST_ACTIVE) begin
         io_out <= mux_out;
         io_oeb <= mux_oeb;
      end else begin
         io_out <= '0;
         io_oeb <= '1;
      end
   end

endmodule
